// File: rtl/zapper_shot.sv
`default_nettype none
// ============================================================================
// zapper_shot : light-gun front end - trigger, two-frame flash, hit test, ammo
// Revision    : 1.0
// ============================================================================
module zapper_shot #(
    parameter int         SHOTS_PER_DUCK  = 3,
    parameter logic [9:0] HIT_RADIUS      = 10'd8,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter logic [1:0] PLAY_STATE      = 2'b10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [1:0] state,
    input  logic       trigger,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] Cross_X,
    input  logic [9:0] Cross_Y,
    input  logic       is_duck,
    input  logic       bird_shot,
    input  logic       flew_away,
    output logic       shot,
    output logic       flash_black,
    output logic       flash_target,
    output logic [1:0] shots_left,
    output logic       out_of_ammo
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_BLACK  = 3'd2,
        S_TARGET = 3'd3,
        S_REPORT = 3'd4,
        S_COOL   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      shots_q, shots_d;
    logic            hit_q, hit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fc_d1_q, fc_d2_q, fe_q;
    logic            trig_s1_q, trig_s2_q, trig_s3_q;

    logic            trig_pulse;
    logic            reload;
    logic            hit_now;
    logic signed [10:0] dx, dy;
    logic [10:0]     adx, ady;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_d1_q   <= 1'b0;
            fc_d2_q   <= 1'b0;
            fe_q      <= 1'b0;
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
        end else begin
            fc_d1_q   <= frame_clk;
            fc_d2_q   <= fc_d1_q;
            fe_q      <= fc_d1_q & ~fc_d2_q;
            trig_s1_q <= trigger;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    assign trig_pulse = trig_s2_q & ~trig_s3_q;
    assign reload     = bird_shot | flew_away;

    // Zero-extend to 11 bits so the window never wraps across a screen edge.
    assign dx      = $signed({1'b0, DrawX}) - $signed({1'b0, Cross_X});
    assign dy      = $signed({1'b0, DrawY}) - $signed({1'b0, Cross_Y});
    assign adx     = dx[10] ? 11'(-dx) : 11'(dx);
    assign ady     = dy[10] ? 11'(-dy) : 11'(dy);
    assign hit_now = is_duck && (adx <= {1'b0, HIT_RADIUS}) && (ady <= {1'b0, HIT_RADIUS});

    always_comb begin
        state_d = state_q;
        shots_d = shots_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        if (state != PLAY_STATE) begin
            state_d = S_IDLE;
            shots_d = 2'(SHOTS_PER_DUCK);
            hit_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig_pulse && shots_q != 2'd0) begin
                        state_d = S_ARM;
                        shots_d = shots_q - 2'd1;
                    end
                end
                S_ARM: begin
                    if (fe_q) begin
                        state_d = S_BLACK;
                        hit_d   = 1'b0;
                    end
                end
                S_BLACK: begin
                    if (fe_q) state_d = S_TARGET;
                end
                S_TARGET: begin
                    if (hit_now) hit_d = 1'b1;
                    if (fe_q) begin
                        if (hit_q || hit_now) begin
                            state_d = S_REPORT;
                        end else begin
                            state_d = S_COOL;
                            cnt_d   = CW'(COOLDOWN_FRAMES);
                        end
                    end
                end
                S_REPORT: begin
                    // A round event means duck has already consumed the shot.
                    if (fe_q || reload) begin
                        state_d = S_COOL;
                        cnt_d   = CW'(COOLDOWN_FRAMES);
                    end
                end
                S_COOL: begin
                    if (cnt_q == '0)  state_d = S_IDLE;
                    else if (fe_q)    cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = S_IDLE;
            endcase
            if (reload) shots_d = 2'(SHOTS_PER_DUCK);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            shots_q <= 2'(SHOTS_PER_DUCK);
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shots_q <= shots_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shot         = (state_q == S_REPORT);
    assign flash_black  = (state_q == S_BLACK);
    assign flash_target = (state_q == S_TARGET);
    assign shots_left   = shots_q;
    assign out_of_ammo  = (shots_q == 2'd0);

endmodule
`default_nettype wire
